// File: rtl/usb_crc16_tx_if.sv
// Bus for the USB CRC16 transmit appender.
// The master side drives the packet controls.
// The slave side (the appender) returns the serial stream and status.
interface usb_crc16_tx_if;
    logic clear;
    logic start;
    logic shift_enable;
    logic d_in;
    logic d_last;
    logic d_out;
    logic crc_active;
    logic busy;
    logic done;

    modport master (
        output clear, start, shift_enable, d_in, d_last,
        input  d_out, crc_active, busy, done
    );

    modport slave (
        input  clear, start, shift_enable, d_in, d_last,
        output d_out, crc_active, busy, done
    );
endinterface

// File: rtl/usb_crc16_tx.sv
// USB CRC16 transmit appender.
// Payload bits pass straight through to d_out. The appender then shifts out
// the inverted 16-bit remainder (polynomial 0x8005, seed 0xFFFF), MSB first.
// A receiver running the same CRC over the whole stream lands on residual 0x800D.
module usb_crc16_tx (
    input  logic            clk,
    input  logic            n_rst,
    usb_crc16_tx_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        CRC  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [15:0] CRC_POLY = 16'h8005;
    localparam logic [15:0] CRC_SEED = 16'hFFFF;

    state_t      state;
    logic [15:0] crc;
    logic [3:0]  bit_cnt;
    logic        busy_q;
    logic        crc_active_q;
    logic        done_q;
    logic        fb;

    // Feedback for the payload CRC update: top remainder bit against the incoming bit.
    assign fb = crc[15] ^ bus.d_in;

    // FSM, CRC register, bit counter and registered status flags.
    // The reset is synchronous. Reset outranks clear, and clear outranks everything else.
    always_ff @(posedge clk) begin
        // NOTE: all sequential state uses non-blocking assignments, so every
        // register samples the values from before the clock edge.
        if (!n_rst || bus.clear) begin
            state        <= IDLE;
            crc          <= CRC_SEED;
            bit_cnt      <= 4'd0;
            busy_q       <= 1'b0;
            crc_active_q <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    // A strobe in the start cycle is not consumed as a data bit.
                    if (bus.start) begin
                        state   <= DATA;
                        crc     <= CRC_SEED;
                        bit_cnt <= 4'd0;
                        busy_q  <= 1'b1;
                    end
                end
                DATA: begin
                    if (bus.shift_enable) begin
                        crc <= {crc[14:0], 1'b0} ^ (fb ? CRC_POLY : 16'h0000);
                        if (bus.d_last) begin
                            state        <= CRC;
                            crc_active_q <= 1'b1;
                        end
                    end
                end
                CRC: begin
                    // Shift ones in behind the remainder. d_out shows its top bit inverted.
                    if (bus.shift_enable) begin
                        crc     <= {crc[14:0], 1'b1};
                        bit_cnt <= bit_cnt + 4'd1;
                        if (bit_cnt == 4'd15) begin
                            state        <= DONE;
                            crc_active_q <= 1'b0;
                            done_q       <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                end
            endcase
        end
    end

    // Serial output mux: payload passthrough, then the inverted remainder MSB first.
    always_comb begin
        // NOTE: default first, so no path through the block leaves d_out unassigned
        // and no latch is inferred.
        bus.d_out = 1'b0;
        case (state)
            DATA:    bus.d_out = bus.d_in;
            CRC:     bus.d_out = ~crc[15];
            default: bus.d_out = 1'b0;
        endcase
    end

    assign bus.busy       = busy_q;
    assign bus.crc_active = crc_active_q;
    assign bus.done       = done_q;

endmodule

// File: tb/tb_usb_crc16_tx.sv
// Self-checking bench for usb_crc16_tx.
// The driver pushes expected wire tokens into a queue. The monitor pops and
// compares them whenever the DUT consumes a strobe or raises done.
// The reference CRC is computed by polynomial long division over GF(2).
module tb_usb_crc16_tx;

    typedef bit bitq_t[$];
    typedef struct {
        bit is_done;
        bit d_out;
        bit crc_active;
    } tok_t;

    logic clk;
    logic n_rst;
    int   tests_run;
    int   tests_failed;
    tok_t exp_q[$];
    bit   rx_bits[$];
    logic [15:0] crc_cap;

    usb_crc16_tx_if bus_if ();

    usb_crc16_tx dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Remainder of a seeded CRC16: the seed 0xFFFF sits on the top 16 dividend bits,
    // the message is shifted up by x^16, and the dividend is divided by x^16+x^15+x^2+1.
    function automatic logic [15:0] poly_rem(input bitq_t m);
        bit a[$];
        logic [16:0] p;
        logic [15:0] r;
        p = 17'h18005;
        a = m;
        repeat (16) a.push_back(1'b0);
        for (int i = 0; i < 16; i++) a[i] = ~a[i];
        for (int i = 0; i < m.size(); i++)
            if (a[i])
                for (int j = 0; j < 17; j++) a[i+j] = a[i+j] ^ p[16-j];
        for (int j = 0; j < 16; j++) r[15-j] = a[m.size()+j];
        return r;
    endfunction

    // Monitor: compare each consumed bit and each done pulse against the queue.
    always @(negedge clk) begin
        if (n_rst && !bus_if.clear) begin
            if (bus_if.done) begin
                bit have;
                have = (exp_q.size() > 0) && exp_q[0].is_done;
                check("done_token", {31'd0, have}, 32'd1);
                if (exp_q.size() > 0) void'(exp_q.pop_front());
                check("rx_residual", {16'd0, poly_rem(rx_bits)}, 32'h800D);
                check("busy_in_done", {31'd0, bus_if.busy}, 32'd1);
            end else if (bus_if.busy && bus_if.shift_enable) begin
                bit have;
                tok_t t;
                have = (exp_q.size() > 0) && !exp_q[0].is_done;
                check("bit_token", {31'd0, have}, 32'd1);
                if (have) begin
                    t = exp_q.pop_front();
                    check("d_out", {31'd0, bus_if.d_out}, {31'd0, t.d_out});
                    check("crc_active", {31'd0, bus_if.crc_active}, {31'd0, t.crc_active});
                end
                rx_bits.push_back(bus_if.d_out);
                if (bus_if.crc_active) crc_cap = {crc_cap[14:0], bus_if.d_out};
            end else if (!bus_if.busy) begin
                check("idle_outputs", {29'd0, bus_if.d_out, bus_if.crc_active, bus_if.done}, 32'd0);
            end
        end
        if (!bus_if.busy) rx_bits.delete();
    end

    task automatic idle_gap(input int max_gap);
        int n;
        n = $urandom_range(max_gap, 0);
        repeat (n) begin
            bus_if.shift_enable = 1'b0;
            bus_if.d_in         = 1'($urandom);
            bus_if.d_last       = 1'($urandom);
            bus_if.start        = 1'($urandom);
            @(posedge clk); #1;
        end
        bus_if.start = 1'b0;
    endtask

    // Drives one packet and pushes the expected tokens. clear_at >= 0 aborts
    // the packet at that CRC bit index.
    task automatic send_packet(input bitq_t pl, input int max_gap, input int clear_at);
        logic [15:0] r;
        r = poly_rem(pl);
        crc_cap = 16'h0;
        @(posedge clk); #1;
        bus_if.start        = 1'b1;
        bus_if.shift_enable = 1'($urandom);
        bus_if.d_in         = 1'($urandom);
        bus_if.d_last       = 1'($urandom);
        @(posedge clk); #1;
        bus_if.start = 1'b0;
        foreach (pl[i]) begin
            idle_gap(max_gap);
            bus_if.shift_enable = 1'b1;
            bus_if.d_in         = pl[i];
            bus_if.d_last       = (i == pl.size() - 1);
            exp_q.push_back('{1'b0, pl[i], 1'b0});
            @(posedge clk); #1;
        end
        for (int k = 0; k < 16; k++) begin
            idle_gap(max_gap);
            if (k == clear_at) begin
                bus_if.clear        = 1'b1;
                bus_if.shift_enable = 1'b1;
                bus_if.start        = 1'b1;
                @(posedge clk); #1;
                bus_if.clear        = 1'b0;
                bus_if.shift_enable = 1'b0;
                bus_if.start        = 1'b0;
                check("clear_busy", {31'd0, bus_if.busy}, 32'd0);
                check("clear_crc_active", {31'd0, bus_if.crc_active}, 32'd0);
                check("clear_done", {31'd0, bus_if.done}, 32'd0);
                @(posedge clk); #1;
                check("clear_no_done_later", {30'd0, bus_if.done, bus_if.busy}, 32'd0);
                return;
            end
            bus_if.shift_enable = 1'b1;
            bus_if.d_in         = 1'($urandom);
            bus_if.d_last       = 1'($urandom);
            exp_q.push_back('{1'b0, ~r[15-k], 1'b1});
            @(posedge clk); #1;
        end
        exp_q.push_back('{1'b1, 1'b0, 1'b0});
        bus_if.shift_enable = 1'b0;
        bus_if.d_last       = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("drained", exp_q.size(), 32'd0);
    endtask

    // Watchdog: the run must never hang.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bitq_t pl;
        logic [31:0] word;
        tests_run    = 0;
        tests_failed = 0;
        crc_cap      = 16'h0;
        n_rst               = 1'b0;
        bus_if.clear        = 1'b0;
        bus_if.start        = 1'b1;
        bus_if.shift_enable = 1'b1;
        bus_if.d_in         = 1'b1;
        bus_if.d_last       = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        bus_if.d_in = 1'b1;
        check("rst_d_out", {31'd0, bus_if.d_out}, 32'd0);
        check("rst_busy", {31'd0, bus_if.busy}, 32'd0);
        check("rst_crc_active", {31'd0, bus_if.crc_active}, 32'd0);
        check("rst_done", {31'd0, bus_if.done}, 32'd0);
        bus_if.start        = 1'b0;
        bus_if.shift_enable = 1'b0;
        n_rst               = 1'b1;
        @(posedge clk); #1;

        // Single-bit payloads with known CRC words.
        pl = '{1'b1};
        send_packet(pl, 0, -1);
        check("vec_bit1_crc", {16'd0, crc_cap}, 32'h0001);
        pl = '{1'b0};
        send_packet(pl, 0, -1);
        check("vec_bit0_crc", {16'd0, crc_cap}, 32'h8004);

        // 32-bit loopback payload, first without gaps and then with random gaps.
        word = 32'h008040C0;
        pl.delete();
        for (int i = 31; i >= 0; i--) pl.push_back(word[i]);
        send_packet(pl, 0, -1);
        check("loop_crc_nogap", {16'd0, crc_cap}, {16'd0, ~poly_rem(pl)});
        send_packet(pl, 5, -1);
        check("loop_crc_gaps", {16'd0, crc_cap}, {16'd0, ~poly_rem(pl)});

        // Random payloads with random stalls.
        for (int n = 0; n < 8; n++) begin
            int len;
            len = $urandom_range(40, 1);
            pl.delete();
            for (int i = 0; i < len; i++) pl.push_back(1'($urandom));
            send_packet(pl, 5, -1);
            check("rand_crc", {16'd0, crc_cap}, {16'd0, ~poly_rem(pl)});
        end

        // Abort at the 8th CRC bit, then check that a fresh packet is clean.
        pl = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        send_packet(pl, 2, 7);
        check("abort_queue_empty", exp_q.size(), 32'd0);
        send_packet(pl, 2, -1);
        check("post_abort_crc", {16'd0, crc_cap}, {16'd0, ~poly_rem(pl)});

        // Reset mid-DATA with start asserted in the same cycle.
        @(posedge clk); #1;
        bus_if.start = 1'b1;
        @(posedge clk); #1;
        bus_if.start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            bus_if.shift_enable = 1'b1;
            bus_if.d_in         = 1'($urandom);
            bus_if.d_last       = 1'b0;
            exp_q.push_back('{1'b0, bus_if.d_in, 1'b0});
            @(posedge clk); #1;
        end
        n_rst               = 1'b0;
        bus_if.start        = 1'b1;
        bus_if.clear        = 1'b1;
        bus_if.shift_enable = 1'b1;
        bus_if.d_in         = 1'b1;
        @(posedge clk); #1;
        check("midrst_busy", {31'd0, bus_if.busy}, 32'd0);
        check("midrst_outputs", {29'd0, bus_if.d_out, bus_if.crc_active, bus_if.done}, 32'd0);
        n_rst               = 1'b1;
        bus_if.start        = 1'b0;
        bus_if.clear        = 1'b0;
        bus_if.shift_enable = 1'b0;
        @(posedge clk); #1;
        check("midrst_start_ignored", {31'd0, bus_if.busy}, 32'd0);
        check("midrst_queue_empty", exp_q.size(), 32'd0);

        // One more packet after the reset, to confirm a clean restart.
        pl = '{1'b0, 1'b1, 1'b1};
        send_packet(pl, 3, -1);
        check("post_reset_crc", {16'd0, crc_cap}, {16'd0, ~poly_rem(pl)});

        repeat (4) @(posedge clk);
        #1;
        check("final_queue_empty", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/usb_crc16_tx.md
USB_CRC16_TX -- requirements
Module: usb_crc16_tx

Interface
REQ-001 SHALL: clk  input  1  system clock; all state updates on rising edge.
REQ-002 SHALL: n_rst  input  1  reset, synchronous, active-low; sampled on rising clk edge.
REQ-003 SHALL: clear  input  1  synchronous abort; returns block to IDLE, CRC register to 0xFFFF.
REQ-004 SHALL: start  input  1  begin new packet; honoured only in IDLE.
REQ-005 SHALL: shift_enable  input  1  bit-time strobe; one data or CRC bit consumed/emitted per asserted cycle.
REQ-006 SHALL: d_in  input  1  serial payload bit, MSB-first, valid when shift_enable=1 in DATA.
REQ-007 SHALL: d_last  input  1  marks current d_in as final payload bit; qualified by shift_enable.
REQ-008 SHALL: d_out  output  1  serial output stream: payload passthrough, then 16 CRC bits.
REQ-009 SHALL: crc_active  output  1  high while CRC bits are presented on d_out.
REQ-010 SHALL: busy  output  1  high in DATA, CRC and DONE.
REQ-011 SHALL: done  output  1  one-cycle pulse after the 16th CRC bit is shifted.

Function
REQ-012 SHALL: FSM states IDLE, DATA, CRC, DONE; state, CRC register and 4-bit CRC bit counter all registered.
REQ-013 SHALL: IDLE -> DATA on start=1; CRC register loaded 0xFFFF, counter 0.
REQ-014 SHALL: in DATA, each shift_enable cycle: fb = crc[15] XOR d_in; crc <= {crc[14:0],1'b0} XOR (fb ? 0x8005 : 0x0000).
REQ-015 SHALL: DATA -> CRC on shift_enable=1 with d_last=1, after that bit's CRC update.
REQ-016 SHALL: in CRC, each shift_enable cycle: crc <= {crc[14:0],1'b1}, counter increments; after the 16th bit (counter=15) -> DONE.
REQ-017 SHALL: DONE -> IDLE unconditionally next cycle; done=1 only in DONE.
REQ-018 SHALL: d_out combinational: DATA = d_in; CRC = NOT crc[15] (inverted remainder, MSB-first); IDLE/DONE = 0.
REQ-019 SHALL: crc_active=1 exactly in CRC; busy=1 in DATA, CRC, DONE.
REQ-020 SHALL: shift_enable=0 holds state, CRC register and counter unchanged (arbitrary-length stalls).
REQ-021 SHALL: d_last with shift_enable=0 ignored; d_last outside DATA ignored.
REQ-022 SHALL: start outside IDLE ignored; start and shift_enable same cycle in IDLE: only start acted on, no bit consumed.
REQ-023 SHALL: clear=1 in any state -> IDLE, crc=0xFFFF, counter=0 next cycle; no done pulse; clear overrides start and shift_enable.
REQ-024 SHALL: appended stream (payload + 16 CRC bits), fed bit-for-bit into the team's USB CRC16 receive checker, produces the USB CRC16 residual (checker pass).

Reset
REQ-025 SHALL: n_rst=0 at rising edge -> state IDLE, crc=0xFFFF, counter=0, regardless of other inputs.
REQ-026 SHALL: after reset d_out=0, crc_active=0, busy=0, done=0.
REQ-027 SHALL: reset asserted mid-DATA or mid-CRC aborts packet with no done pulse; n_rst has priority over clear.

Verification
REQ-028 SHALL: start; one bit d_in=1,d_last=1 -> 16 CRC bits on d_out = 0x0001 MSB-first, crc_active high 16 strobes, done pulse 1 cycle later.
REQ-029 SHALL: start; one bit d_in=0,d_last=1 -> CRC bits = 0x8004 MSB-first, then done.
REQ-030 SHALL: loopback: 32-bit payload 0x008040C0 plus generated CRC into receive checker (same clk/shift_enable) -> checker crc_check_16=1 after final CRC bit.
REQ-031 SHALL: random 0-5 cycle gaps between shift_enable strobes during DATA and CRC -> CRC bits identical to no-gap run.
REQ-032 SHALL: clear asserted at 8th CRC bit -> IDLE next cycle, busy=0, no done; following packet produces correct CRC.
REQ-033 SHALL: n_rst=0 mid-DATA, start asserted in same cycle -> IDLE, all outputs 0, start ignored.
